// File: rtl/asic_ioring_pkg.sv
// rtl/asic_ioring_pkg.sv - shared state encoding and timer sizing for the IO ring sequencer
package asic_ioring_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        CHECK,
        READY,
        DOWN,
        ERR
    } ioring_state_t;

    localparam int TIMEOUT_DFLT = 200;
    localparam int TMR_W        = $clog2(TIMEOUT_DFLT + 1);

endpackage

// File: rtl/asic_ioring_sync.sv
// rtl/asic_ioring_sync.sv - parameterized-width 2-flop synchronizer
// Ports:
//   i_clk   : destination clock
//   i_reset : asynchronous active-high reset, clears both stages
//   i_d     : asynchronous input bits
//   o_q     : synchronized output bits
module asic_ioring_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/asic_ioring_seq.sv
// rtl/asic_ioring_seq.sv - padring ctrl ring power-up/down sequencer with sense monitoring
// Ports:
//   clk, reset : core clock, asynchronous active-high reset
//   en         : level request, 1 = ring up, 0 = ring down / clear error
//   delay      : cycles between steps (step period = delay+1), latched on UP/DOWN entry
//   ctrl_out   : driven ring bits ctrlring[NDRV-1:0]
//   sense_in   : asynchronous ring sense bits ctrlring[NCTRL-1:NDRV]
//   sense      : synchronized sense_in
//   busy       : UP, CHECK or DOWN in progress
//   ready      : ring up and all sense bits high
//   error      : timeout or sense loss
module asic_ioring_seq
    import asic_ioring_pkg::*;
#(
    parameter int NCTRL   = 8,
    parameter int NDRV    = 4,
    parameter int CW      = 8,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [CW-1:0]         delay,
    output logic [NDRV-1:0]       ctrl_out,
    input  logic [NCTRL-NDRV-1:0] sense_in,
    output logic [NCTRL-NDRV-1:0] sense,
    output logic                  busy,
    output logic                  ready,
    output logic                  error
);

    // A smaller TIMEOUT always fits in the default timer width.
    localparam int TW = (TIMEOUT > TIMEOUT_DFLT) ? $clog2(TIMEOUT + 1) : TMR_W;
    localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [NDRV-1:0] BIT0     = NDRV'(1);

    ioring_state_t   r_state;
    ioring_state_t   w_state_nxt;
    logic [NDRV-1:0] r_ctrl;
    logic [NDRV-1:0] w_ctrl_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   r_dly;
    logic [CW-1:0]   w_dly_nxt;
    logic [TW-1:0]   r_tmr;
    logic [TW-1:0]   w_tmr_nxt;
    logic            r_busy;
    logic            r_ready;
    logic            r_error;

    logic            w_step;
    logic            w_sense_ok;
    logic [NDRV-1:0] w_ctrl_up;

    asic_ioring_sync #(
        .W (NCTRL - NDRV)
    ) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (sense_in),
        .o_q     (sense)
    );

    assign w_step     = (r_cnt == r_dly);
    assign w_sense_ok = &sense;
    // Bits are raised in order 0..NDRV-1, so ctrl_out is a thermometer code:
    // raising the next bit is a shift-in of 1, clearing the highest is a shift right.
    assign w_ctrl_up  = (r_ctrl << 1) | BIT0;

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_cnt_nxt   = r_cnt;
        w_dly_nxt   = r_dly;
        w_tmr_nxt   = r_tmr;

        case (r_state)
            IDLE: begin
                w_ctrl_nxt = '0;
                if (en) w_state_nxt = UP;
            end
            UP: begin
                if (!en) begin
                    w_state_nxt = DOWN;
                end else if (w_step) begin
                    w_ctrl_nxt = w_ctrl_up;
                    w_cnt_nxt  = '0;
                    if (w_ctrl_up[NDRV-1]) w_state_nxt = CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CHECK: begin
                if (!en) begin
                    w_state_nxt = DOWN;
                end else if (w_sense_ok) begin
                    w_state_nxt = READY;
                end else if (r_tmr == TMR_LAST) begin
                    w_state_nxt = ERR;
                    w_ctrl_nxt  = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            READY: begin
                if (!en) begin
                    w_state_nxt = DOWN;
                end else if (!w_sense_ok) begin
                    w_state_nxt = ERR;
                    w_ctrl_nxt  = '0;
                end
            end
            DOWN: begin
                if (r_ctrl == '0) begin
                    w_state_nxt = IDLE;
                end else if (w_step) begin
                    w_ctrl_nxt = r_ctrl >> 1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ERR: begin
                w_ctrl_nxt = '0;
                if (!en) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ctrl_nxt  = '0;
            end
        endcase

        // Step timing restarts and delay is captured only when a ramp begins.
        if ((w_state_nxt != r_state) && ((w_state_nxt == UP) || (w_state_nxt == DOWN))) begin
            w_cnt_nxt = '0;
            w_dly_nxt = delay;
        end
        if ((w_state_nxt == CHECK) && (r_state != CHECK)) w_tmr_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
            r_cnt   <= '0;
            r_dly   <= '0;
            r_tmr   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dly   <= w_dly_nxt;
            r_tmr   <= w_tmr_nxt;
            r_busy  <= (w_state_nxt == UP) || (w_state_nxt == CHECK) || (w_state_nxt == DOWN);
            // Status follows the state one cycle later and is exclusive by construction.
            r_ready <= (r_state == READY);
            r_error <= (r_state == ERR);
        end
    end

    assign ctrl_out = r_ctrl;
    assign busy     = r_busy;
    assign ready    = r_ready;
    assign error    = r_error;

endmodule

// File: tb/tb_asic_ioring_seq.sv
// tb/tb_asic_ioring_seq.sv - self-checking bench for asic_ioring_seq
module tb_asic_ioring_seq;

    localparam int NCTRL   = 8;
    localparam int NDRV    = 4;
    localparam int CW      = 8;
    localparam int TIMEOUT = 200;
    localparam int NS      = NCTRL - NDRV;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [CW-1:0]   delay;
    logic [NDRV-1:0] ctrl_out;
    logic [NS-1:0]   sense_in;
    logic [NS-1:0]   sense;
    logic            busy;
    logic            ready;
    logic            error;

    typedef struct {
        logic [NDRV-1:0] val;
        int              cyc;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            mon_e;
    logic [NDRV-1:0] mon_last = '0;
    bit              sb_on    = 1'b0;
    int              cyc      = 0;
    int              n_checks = 0;
    int              n_fail   = 0;

    asic_ioring_seq #(
        .NCTRL   (NCTRL),
        .NDRV    (NDRV),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .delay    (delay),
        .ctrl_out (ctrl_out),
        .sense_in (sense_in),
        .sense    (sense),
        .busy     (busy),
        .ready    (ready),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every change of ctrl_out must match the next expected (value, edge).
    always @(negedge clk) begin
        if (sb_on && (ctrl_out !== mon_last)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL ctrl_unexpected: got %b at cycle %0d, no change expected", ctrl_out, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if ((ctrl_out !== mon_e.val) || (cyc != mon_e.cyc)) begin
                    n_fail++;
                    $display("FAIL ctrl_step: got %b at cycle %0d, want %b at cycle %0d",
                             ctrl_out, cyc, mon_e.val, mon_e.cyc);
                end
            end
        end
        mon_last = ctrl_out;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_ctrl(input logic [NDRV-1:0] v, input int c);
        sb_q.push_back('{val: v, cyc: c});
    endtask

    task automatic wait_sb(input string name, input int budget);
        int n = 0;
        while ((sb_q.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d ctrl steps missing after %0d cycles, want 0", name, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic go_idle();
        int n = 0;
        sb_on = 1'b0;
        en    = 1'b0;
        tick(3);
        while (!((busy === 1'b0) && (ctrl_out === '0) && (ready === 1'b0) && (error === 1'b0)) && (n < 100)) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL go_idle: busy=%b ctrl=%b ready=%b error=%b, want all 0", busy, ctrl_out, ready, error);
        end
        sb_on = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        en       = 1'b0;
        delay    = '0;
        sense_in = '1;
        tick(3);
        n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", ctrl_out); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_checks++; if (sense !== '0)    begin n_fail++; $display("FAIL reset_sense: got %b want 0", sense); end
        reset = 1'b0;
        tick(3);
        n_checks++; if (sense !== '1)    begin n_fail++; $display("FAIL sync_sense: got %b want 1111", sense); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        sb_on = 1'b1;
    endtask

    task automatic test_power_up();
        int t;
        int n = 0;
        delay = 8'd3;
        en    = 1'b1;
        t     = cyc + 1;
        push_ctrl(4'b0001, t + 4);
        push_ctrl(4'b0011, t + 8);
        push_ctrl(4'b0111, t + 12);
        push_ctrl(4'b1111, t + 16);
        wait_sb("up_nominal", 40);
        n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL up_check_busy: got %b want 1", busy); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL up_check_ready: got %b want 0", ready); end
        while ((ready !== 1'b1) && (n < 10)) begin tick(); n++; end
        n_checks++; if (cyc != t + 18)  begin n_fail++; $display("FAIL ready_latency: got cycle %0d want %0d", cyc, t + 18); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL ready_busy: got %b want 0", busy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL ready_error: got %b want 0", error); end
    endtask

    task automatic test_sense_loss();
        int c;
        sense_in = 4'b1101;
        c        = cyc;
        push_ctrl(4'b0000, c + 3);
        wait_sb("sense_loss", 10);
        n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL loss_error_lag: got %b want 0", error); end
        tick();
        n_checks++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL loss_ready: got %b want 0", ready); end
        n_checks++; if (error !== 1'b1)  begin n_fail++; $display("FAIL loss_error: got %b want 1", error); end
        n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL loss_ctrl: got %b want 0", ctrl_out); end
        sense_in = '1;
        go_idle();
    endtask

    task automatic test_timeout();
        int t;
        delay    = 8'd0;
        sense_in = '0;
        en       = 1'b1;
        t        = cyc + 1;
        push_ctrl(4'b0001, t + 1);
        push_ctrl(4'b0011, t + 2);
        push_ctrl(4'b0111, t + 3);
        push_ctrl(4'b1111, t + 4);
        push_ctrl(4'b0000, t + 4 + TIMEOUT);
        wait_sb("timeout", TIMEOUT + 60);
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
        tick();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b want 1", error); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL tmo_ready: got %b want 0", ready); end
        en = 1'b0;
        tick();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error_hold: got %b want 1", error); end
        tick();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_error_clear: got %b want 0", error); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL tmo_idle_busy: got %b want 0", busy); end
        sense_in = '1;
    endtask

    task automatic test_abort();
        int t;
        delay = 8'd2;
        en    = 1'b1;
        t     = cyc + 1;
        push_ctrl(4'b0001, t + 3);
        push_ctrl(4'b0011, t + 6);
        wait_sb("abort_up", 20);
        en = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b want 1", busy); end
        en = 1'b1;
        push_ctrl(4'b0001, t + 10);
        push_ctrl(4'b0000, t + 13);
        push_ctrl(4'b0001, t + 18);
        wait_sb("abort_down", 30);
        go_idle();
    endtask

    task automatic test_delay_change();
        int t;
        delay = 8'd3;
        en    = 1'b1;
        t     = cyc + 1;
        push_ctrl(4'b0001, t + 4);
        wait_sb("dly_first", 20);
        delay = 8'd0;
        push_ctrl(4'b0011, t + 8);
        push_ctrl(4'b0111, t + 12);
        wait_sb("dly_up", 20);
        en = 1'b0;
        push_ctrl(4'b0011, t + 14);
        push_ctrl(4'b0001, t + 15);
        push_ctrl(4'b0000, t + 16);
        wait_sb("dly_down", 20);
        go_idle();
    endtask

    task automatic test_async_reset();
        int t;
        int n = 0;
        delay    = 8'd0;
        sense_in = '1;
        en       = 1'b1;
        t        = cyc + 1;
        push_ctrl(4'b0001, t + 1);
        push_ctrl(4'b0011, t + 2);
        push_ctrl(4'b0111, t + 3);
        push_ctrl(4'b1111, t + 4);
        wait_sb("ares_pre", 20);
        while ((ready !== 1'b1) && (n < 10)) begin tick(); n++; end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ares_pre_ready: got %b want 1", ready); end
        sb_on = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL ares_ctrl: got %b want 0", ctrl_out); end
        n_checks++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL ares_ready: got %b want 0", ready); end
        n_checks++; if (sense !== '0)    begin n_fail++; $display("FAIL ares_sense: got %b want 0", sense); end
        reset = 1'b0;
        t     = cyc + 1;
        tick();
        sb_on = 1'b1;
        push_ctrl(4'b0001, t + 1);
        push_ctrl(4'b0011, t + 2);
        push_ctrl(4'b0111, t + 3);
        push_ctrl(4'b1111, t + 4);
        wait_sb("ares_rerun", 20);
        n = 0;
        while ((ready !== 1'b1) && (n < 10)) begin tick(); n++; end
        n_checks++; if (cyc != t + 6)  begin n_fail++; $display("FAIL ares_ready_latency: got cycle %0d want %0d", cyc, t + 6); end
        n_checks++; if (sense !== '1)  begin n_fail++; $display("FAIL ares_sense_resync: got %b want 1111", sense); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sense_loss();
        test_timeout();
        test_abort();
        test_delay_change();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
